// File: rtl/wishbone_to_gpmc.sv
// Wishbone classic slave to GPMC muxed address/data initiator; `GPMC_WAIT_EN adds the synchronised gpmc_wait stall.
// Latency: ack 1+ADDR+DATA cycles after acceptance (write), 1+ADDR+TURN+DATA (read), plus any wait stall.
// Backpressure: one transaction in flight; requests are only accepted in IDLE and held off until ack.
module wishbone_to_gpmc #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_CYCLES = 2,
    parameter int TURN_CYCLES = 1,
    parameter int DATA_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_write,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack,
    output logic [DATA_WIDTH-1:0] gpmc_ad_o,
    output logic                  gpmc_ad_oe,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_i,
    output logic                  gpmc_advn,
    output logic                  gpmc_csn,
    output logic                  gpmc_wein,
    output logic                  gpmc_oen,
    output logic                  gpmc_clk
`ifdef GPMC_WAIT_EN
    ,
    input  logic                  gpmc_wait
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_TURN,
        S_RDATA,
        S_RECOVER
    } state_t;

    localparam logic [7:0] ADDR_LAST = 8'(ADDR_CYCLES - 1);
    localparam logic [7:0] TURN_LAST = 8'(TURN_CYCLES - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_write;
    logic                  r_abort;
    logic [DATA_WIDTH-1:0] r_readdata;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_ad_o;
    logic                  r_ad_oe;
    logic                  r_advn;
    logic                  r_csn;
    logic                  r_wein;
    logic                  r_oen;
    logic                  r_gpmc_clk;
    logic                  w_wait_ok;
    logic                  w_data_last;
    logic                  w_ack_ok;

`ifdef GPMC_WAIT_EN
    logic r_wait_s1;
    logic r_wait_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_s1 <= 1'b1;
            r_wait_s2 <= 1'b1;
        end else begin
            r_wait_s1 <= gpmc_wait;
            r_wait_s2 <= r_wait_s1;
        end
    end

    assign w_wait_ok = r_wait_s2;
`else
    assign w_wait_ok = 1'b1;
`endif

    assign w_data_last = (r_cnt == DATA_LAST);
    // A master that dropped wbs_cycle at any point during the bus cycle gets no ack.
    assign w_ack_ok    = wbs_cycle && !r_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_abort    <= 1'b0;
            r_readdata <= '0;
            r_ack      <= 1'b0;
            r_ad_o     <= '0;
            r_ad_oe    <= 1'b0;
            r_advn     <= 1'b1;
            r_csn      <= 1'b1;
            r_wein     <= 1'b1;
            r_oen      <= 1'b1;
            r_gpmc_clk <= 1'b0;
        end else begin
            if (r_state != S_IDLE && !wbs_cycle) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_gpmc_clk <= 1'b0;
                    if (wbs_cycle && wbs_strobe && !r_ack) begin
                        r_state    <= S_ADDR;
                        r_cnt      <= '0;
                        r_wdata    <= wbs_writedata;
                        r_write    <= wbs_write;
                        r_abort    <= 1'b0;
                        r_ad_o     <= DATA_WIDTH'(wbs_address);
                        r_ad_oe    <= 1'b1;
                        r_csn      <= 1'b0;
                        r_advn     <= 1'b0;
                        r_gpmc_clk <= 1'b1;
                    end
                end
                S_ADDR: begin
                    r_gpmc_clk <= ~r_gpmc_clk;
                    if (r_cnt == ADDR_LAST) begin
                        r_cnt  <= '0;
                        r_advn <= 1'b1;
                        if (r_write) begin
                            r_state <= S_WDATA;
                            r_ad_o  <= r_wdata;
                            r_wein  <= 1'b0;
                        end else begin
                            r_state <= S_TURN;
                            r_ad_oe <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_TURN: begin
                    r_gpmc_clk <= ~r_gpmc_clk;
                    if (r_cnt == TURN_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_RDATA;
                        r_oen   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WDATA, S_RDATA: begin
                    r_gpmc_clk <= ~r_gpmc_clk;
                    if (w_wait_ok) begin
                        if (w_data_last) begin
                            r_state    <= S_RECOVER;
                            r_cnt      <= '0;
                            r_ad_oe    <= 1'b0;
                            r_wein     <= 1'b1;
                            r_oen      <= 1'b1;
                            r_csn      <= 1'b1;
                            r_gpmc_clk <= 1'b0;
                            r_ack      <= w_ack_ok;
                            if (r_state == S_RDATA && w_ack_ok) begin
                                r_readdata <= gpmc_ad_i;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_RECOVER: begin
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign wbs_readdata = r_readdata;
    assign wbs_ack      = r_ack;
    assign gpmc_ad_o    = r_ad_o;
    assign gpmc_ad_oe   = r_ad_oe;
    assign gpmc_advn    = r_advn;
    assign gpmc_csn     = r_csn;
    assign gpmc_wein    = r_wein;
    assign gpmc_oen     = r_oen;
    assign gpmc_clk     = r_gpmc_clk;

endmodule

// File: tb/tb_wishbone_to_gpmc.sv
// Directed bench for wishbone_to_gpmc: cycle-exact strobe/AD checks, back-to-back, abort and reset cases.
module tb_wishbone_to_gpmc;

    logic        clk;
    logic        reset;
    logic [15:0] wbs_address;
    logic [15:0] wbs_writedata;
    logic [15:0] wbs_readdata;
    logic        wbs_write;
    logic        wbs_strobe;
    logic        wbs_cycle;
    logic        wbs_ack;
    logic [15:0] gpmc_ad_o;
    logic        gpmc_ad_oe;
    logic [15:0] gpmc_ad_i;
    logic        gpmc_advn;
    logic        gpmc_csn;
    logic        gpmc_wein;
    logic        gpmc_oen;
    logic        gpmc_clk;
`ifdef GPMC_WAIT_EN
    logic        gpmc_wait;
`endif

    logic [15:0] bus_rd;
    logic [6:0]  obs_s;
    int          tests;
    int          fails;

    wishbone_to_gpmc dut (
        .clk          (clk),
        .reset        (reset),
        .wbs_address  (wbs_address),
        .wbs_writedata(wbs_writedata),
        .wbs_readdata (wbs_readdata),
        .wbs_write    (wbs_write),
        .wbs_strobe   (wbs_strobe),
        .wbs_cycle    (wbs_cycle),
        .wbs_ack      (wbs_ack),
        .gpmc_ad_o    (gpmc_ad_o),
        .gpmc_ad_oe   (gpmc_ad_oe),
        .gpmc_ad_i    (gpmc_ad_i),
        .gpmc_advn    (gpmc_advn),
        .gpmc_csn     (gpmc_csn),
        .gpmc_wein    (gpmc_wein),
        .gpmc_oen     (gpmc_oen),
        .gpmc_clk     (gpmc_clk)
`ifdef GPMC_WAIT_EN
        ,
        .gpmc_wait    (gpmc_wait)
`endif
    );

    // Responder model: drives read data only while output enable is asserted.
    assign gpmc_ad_i = gpmc_oen ? 16'h5A5A : bus_rd;
    assign obs_s = {gpmc_csn, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_ad_oe, gpmc_clk, wbs_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic we, input logic [15:0] a, input logic [15:0] d);
        wbs_write     = we;
        wbs_address   = a;
        wbs_writedata = d;
        wbs_cycle     = 1'b1;
        wbs_strobe    = 1'b1;
    endtask

    task automatic drop();
        wbs_cycle  = 1'b0;
        wbs_strobe = 1'b0;
    endtask

    task automatic run_read(input string tag, input logic [15:0] a, input logic [15:0] v);
        int ack_at;
        ack_at = -1;
        bus_rd = v;
        request(1'b0, a, 16'h0000);
        for (int c = 1; c <= 12 && ack_at < 0; c++) begin
            tick();
            if (wbs_ack) begin
                ack_at = c;
                chk({tag, " rdata"}, 32'(wbs_readdata), 32'(v));
                drop();
            end
        end
        chk({tag, " ack cycle"}, 32'(ack_at), 32'd8);
        drop();
        tick();
    endtask

    initial begin
        logic       a_ph, d_ph, t_ph, r_ph, act;
        logic [6:0] exp_s;
        int         acks;
        int         weins;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus_rd = 16'h0000;
        drop();
        wbs_write = 1'b0;
        wbs_address = 16'h0000;
        wbs_writedata = 16'h0000;
`ifdef GPMC_WAIT_EN
        gpmc_wait = 1'b1;
`endif
        tick();
        tick();
        reset = 1'b0;
        chk("reset strobes", 32'(obs_s), 32'(7'b1111000));
        chk("reset ad_o", 32'(gpmc_ad_o), 32'h0);
        chk("reset rdata", 32'(wbs_readdata), 32'h0);

        // Write 0x1234 @ 0x00A5; inputs scrambled after acceptance must not matter.
        request(1'b1, 16'h00A5, 16'h1234);
        for (int c = 1; c <= 8; c++) begin
            tick();
            a_ph  = (c <= 2);
            d_ph  = (c >= 3 && c <= 6);
            act   = a_ph || d_ph;
            exp_s = {!act, !a_ph, !d_ph, 1'b1, act, act && (c % 2 == 1), c == 7};
            chk($sformatf("wr strobes c%0d", c), 32'(obs_s), 32'(exp_s));
            if (a_ph) chk($sformatf("wr addr c%0d", c), 32'(gpmc_ad_o), 32'h00A5);
            if (d_ph) chk($sformatf("wr data c%0d", c), 32'(gpmc_ad_o), 32'h1234);
            if (c == 1) begin
                wbs_address   = 16'h0F0F;
                wbs_writedata = 16'hDEAD;
            end
            if (c == 7) drop();
        end

        // Read @ 0x0010 returning 0xBEEF.
        bus_rd = 16'hBEEF;
        request(1'b0, 16'h0010, 16'h0000);
        for (int c = 1; c <= 9; c++) begin
            tick();
            a_ph  = (c <= 2);
            t_ph  = (c == 3);
            r_ph  = (c >= 4 && c <= 7);
            act   = a_ph || t_ph || r_ph;
            exp_s = {!act, !a_ph, 1'b1, !r_ph, a_ph, act && (c % 2 == 1), c == 8};
            chk($sformatf("rd strobes c%0d", c), 32'(obs_s), 32'(exp_s));
            if (a_ph) chk($sformatf("rd addr c%0d", c), 32'(gpmc_ad_o), 32'h0010);
            if (c == 7) chk("rd data before ack", 32'(wbs_readdata), 32'h0);
            if (c == 8) begin
                chk("rd data at ack", 32'(wbs_readdata), 32'hBEEF);
                drop();
            end
        end

        // Write then read back-to-back: a single IDLE cycle (cycle 8) precedes the second ADDR.
        acks = 0;
        request(1'b1, 16'h0003, 16'h5555);
        for (int c = 1; c <= 17; c++) begin
            tick();
            if (wbs_ack) acks++;
            if (c == 7) begin
                chk("b2b write ack", 32'(wbs_ack), 32'h1);
                bus_rd = 16'hCAFE;
                request(1'b0, 16'h0004, 16'h0000);
            end
            if (c == 8) chk("b2b idle csn/ack", 32'({gpmc_csn, wbs_ack}), 32'(2'b10));
            if (c == 9) chk("b2b second addr", 32'({gpmc_csn, gpmc_advn, gpmc_ad_o}), 32'({2'b00, 16'h0004}));
            if (c == 16) begin
                chk("b2b read ack", 32'(wbs_ack), 32'h1);
                chk("b2b read data", 32'(wbs_readdata), 32'hCAFE);
                drop();
            end
        end
        chk("b2b ack count", 32'(acks), 32'd2);

        // Master drops wbs_cycle during WDATA: bus write completes, no ack, readdata untouched.
        acks = 0;
        weins = 0;
        request(1'b1, 16'h0077, 16'h00FF);
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (!gpmc_wein) weins++;
            if (wbs_ack) acks++;
            if (c == 4) drop();
        end
        chk("abort wein cycles", 32'(weins), 32'd4);
        chk("abort ack count", 32'(acks), 32'd0);
        chk("abort rdata held", 32'(wbs_readdata), 32'hCAFE);
        run_read("post-abort read", 16'h0020, 16'h1357);

        // Reset during RDATA discards the read.
        bus_rd = 16'h2468;
        request(1'b0, 16'h0030, 16'h0000);
        for (int c = 1; c <= 5; c++) tick();
        chk("pre-reset in rdata", 32'({gpmc_csn, gpmc_oen}), 32'(2'b00));
        reset = 1'b1;
        tick();
        chk("mid reset strobes", 32'(obs_s), 32'(7'b1111000));
        chk("mid reset rdata", 32'(wbs_readdata), 32'h0);
        reset = 1'b0;
        drop();
        tick();
        run_read("post-reset read", 16'h0040, 16'h9ABC);

`ifdef GPMC_WAIT_EN
        // Wait low for cycles 4..8 stalls the data counter for 5 synced cycles: ack at 13.
        begin
            int ack_at;
            ack_at = -1;
            bus_rd = 16'h7E57;
            request(1'b0, 16'h0050, 16'h0000);
            for (int c = 1; c <= 20 && ack_at < 0; c++) begin
                tick();
                if (c == 4) gpmc_wait = 1'b0;
                if (c == 9) gpmc_wait = 1'b1;
                if (wbs_ack) begin
                    ack_at = c;
                    chk("wait rdata", 32'(wbs_readdata), 32'h7E57);
                end
            end
            chk("wait ack cycle", 32'(ack_at), 32'd13);
            drop();
            tick();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
